// File: rtl/bus_pkg.sv
// Shared types and constants for the core bus and its arbiter.
package bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'b00,
    ARB_GRANT_I = 2'b01,
    ARB_GRANT_D = 2'b10
  } arb_state_e;

  localparam logic [3:0] BUS_WSTRB_READ = 4'b0000;

endpackage

// File: rtl/bus_if.sv
// Simple valid/ready core bus: one transfer completes in the cycle valid && ready.
interface bus_if;
  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        instr;

  modport master (
    output valid, addr, wstrb, write_data, instr,
    input  ready, read_data
  );

  modport slave (
    input  valid, addr, wstrb, write_data, instr,
    output ready, read_data
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master (instruction fetch, load/store) to one-slave arbiter with registered grants,
// optional fixed data priority, and a saturating contention counter.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned DATA_PRIORITY = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  bus_if.slave        instr_bus,
  bus_if.slave        data_bus,
  bus_if.master       mem_bus,
  output logic [1:0]  grant_o,
  output logic [15:0] contention_cnt_o
);

  localparam bit DataPrio = (DATA_PRIORITY != 0);

  arb_state_e  state_q;
  logic        last_d_q;
  logic [15:0] cnt_q;
  logic        contend;
  logic        done;

  always_comb begin
    contend = (instr_bus.valid && (state_q != ARB_GRANT_I)) ||
              (data_bus.valid && (state_q != ARB_GRANT_D));
    done    = mem_bus.valid && mem_bus.ready;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ARB_IDLE;
      last_d_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (contend && (cnt_q != 16'hFFFF)) begin
        cnt_q <= cnt_q + 16'd1;
      end
      case (state_q)
        ARB_IDLE: begin
          if (instr_bus.valid && data_bus.valid) begin
            // Tie: fixed priority, else the master that was not served last.
            state_q <= (DataPrio || !last_d_q) ? ARB_GRANT_D : ARB_GRANT_I;
          end else if (instr_bus.valid) begin
            state_q <= ARB_GRANT_I;
          end else if (data_bus.valid) begin
            state_q <= ARB_GRANT_D;
          end
        end
        ARB_GRANT_I: begin
          if (!instr_bus.valid) begin
            state_q <= ARB_IDLE;
          end else if (done) begin
            last_d_q <= 1'b0;
            state_q  <= data_bus.valid ? ARB_GRANT_D : ARB_IDLE;
          end
        end
        ARB_GRANT_D: begin
          if (!data_bus.valid) begin
            state_q <= ARB_IDLE;
          end else if (done) begin
            last_d_q <= 1'b1;
            // Under data priority, always re-arbitrate from idle after a data transfer.
            state_q  <= (instr_bus.valid && !DataPrio) ? ARB_GRANT_I : ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_bus.valid       = 1'b0;
    mem_bus.addr        = '0;
    mem_bus.wstrb       = BUS_WSTRB_READ;
    mem_bus.write_data  = '0;
    mem_bus.instr       = 1'b0;
    instr_bus.ready     = 1'b0;
    instr_bus.read_data = '0;
    data_bus.ready      = 1'b0;
    data_bus.read_data  = '0;
    case (state_q)
      ARB_GRANT_I: begin
        mem_bus.valid       = instr_bus.valid;
        mem_bus.addr        = instr_bus.addr;
        mem_bus.wstrb       = instr_bus.wstrb;
        mem_bus.write_data  = instr_bus.write_data;
        mem_bus.instr       = instr_bus.instr;
        instr_bus.ready     = mem_bus.ready;
        instr_bus.read_data = mem_bus.read_data;
      end
      ARB_GRANT_D: begin
        mem_bus.valid       = data_bus.valid;
        mem_bus.addr        = data_bus.addr;
        mem_bus.wstrb       = data_bus.wstrb;
        mem_bus.write_data  = data_bus.write_data;
        mem_bus.instr       = data_bus.instr;
        data_bus.ready      = mem_bus.ready;
        data_bus.read_data  = mem_bus.read_data;
      end
      default: ;
    endcase
  end

  assign grant_o          = state_q;
  assign contention_cnt_o = cnt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a per-cycle vector table on a round-robin instance plus
// hand-written reset and data-priority sequences.
module tb_bus_arbiter;

  logic        clk;
  logic        rst_ni;
  logic [1:0]  g_rr, g_dp;
  logic [15:0] c_rr, c_dp;

  bus_if ib0 ();
  bus_if db0 ();
  bus_if mb0 ();
  bus_if ib1 ();
  bus_if db1 ();
  bus_if mb1 ();

  bus_arbiter #(.DATA_PRIORITY(0)) u_rr (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .instr_bus        (ib0),
    .data_bus         (db0),
    .mem_bus          (mb0),
    .grant_o          (g_rr),
    .contention_cnt_o (c_rr)
  );

  bus_arbiter #(.DATA_PRIORITY(1)) u_dp (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .instr_bus        (ib1),
    .data_bus         (db1),
    .mem_bus          (mb1),
    .grant_o          (g_dp),
    .contention_cnt_o (c_dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, iv, dv, sr;
    logic [31:0] srd;
    logic [1:0]  g;
    logic        mv, ir, dr;
    logic [31:0] ird, drd;
    logic [15:0] cnt;
  } vec_t;

  localparam int NV = 30;
  vec_t tbl [NV];
  int n_run  = 0;
  int n_fail = 0;

  function automatic vec_t mk(logic rst, logic iv, logic dv, logic sr, logic [31:0] srd,
                              logic [1:0] g, logic mv, logic ir, logic dr,
                              logic [31:0] ird, logic [31:0] drd, logic [15:0] cnt);
    vec_t v;
    v.rst = rst; v.iv = iv; v.dv = dv; v.sr = sr; v.srd = srd;
    v.g = g; v.mv = mv; v.ir = ir; v.dr = dr; v.ird = ird; v.drd = drd; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  // Request fields the slave should see for each grant (instr reads 0x100, data writes 0x200).
  function automatic logic [31:0] exp_addr(logic [1:0] g);
    return (g == 2'b01) ? 32'h0000_0100 : (g == 2'b10) ? 32'h0000_0200 : 32'h0;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ni, nd;
    rst_ni = 1'b0;
    ib0.valid = 0; ib0.addr = 32'h100; ib0.wstrb = 4'h0; ib0.write_data = '0; ib0.instr = 1;
    db0.valid = 0; db0.addr = 32'h200; db0.wstrb = 4'hF; db0.write_data = 32'h1234_5678;
    db0.instr = 0;
    ib1.valid = 0; ib1.addr = 32'h100; ib1.wstrb = 4'h0; ib1.write_data = '0; ib1.instr = 1;
    db1.valid = 0; db1.addr = 32'h200; db1.wstrb = 4'hF; db1.write_data = 32'h1234_5678;
    db1.instr = 0;
    mb0.ready = 0; mb0.read_data = '0;
    mb1.ready = 0; mb1.read_data = '0;

    //           rst iv dv sr srd            g  mv ir dr ird            drd            cnt
    tbl[0]  = mk(0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0,         32'h0,         0);
    tbl[1]  = mk(0, 1, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0,         32'h0,         0);
    tbl[2]  = mk(0, 1, 0, 0, 32'h0,         1, 1, 0, 0, 32'h0,         32'h0,         1);
    tbl[3]  = mk(0, 1, 0, 0, 32'h0,         1, 1, 0, 0, 32'h0,         32'h0,         1);
    tbl[4]  = mk(0, 1, 0, 1, 32'hDEAD_BEEF, 1, 1, 1, 0, 32'hDEAD_BEEF, 32'h0,         1);
    tbl[5]  = mk(0, 0, 0, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 32'h0,         32'h0,         1);
    tbl[6]  = mk(1, 0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0,         32'h0,         0);
    tbl[7]  = mk(0, 1, 1, 1, 32'h0,         0, 0, 0, 0, 32'h0,         32'h0,         0);
    tbl[8]  = mk(0, 1, 1, 1, 32'hA5A5_0000, 2, 1, 0, 1, 32'h0,         32'hA5A5_0000, 1);
    tbl[9]  = mk(0, 1, 0, 1, 32'hCAFE_F00D, 1, 1, 1, 0, 32'hCAFE_F00D, 32'h0,         2);
    tbl[10] = mk(0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0,         32'h0,         2);
    tbl[11] = mk(0, 1, 1, 1, 32'h0,         0, 0, 0, 0, 32'h0,         32'h0,         2);
    tbl[12] = mk(0, 1, 1, 1, 32'h0,         2, 1, 0, 1, 32'h0,         32'h0,         3);
    tbl[13] = mk(0, 1, 1, 1, 32'h0,         1, 1, 1, 0, 32'h0,         32'h0,         4);
    tbl[14] = mk(0, 1, 1, 1, 32'h0,         2, 1, 0, 1, 32'h0,         32'h0,         5);
    tbl[15] = mk(0, 1, 1, 1, 32'h0,         1, 1, 1, 0, 32'h0,         32'h0,         6);
    tbl[16] = mk(0, 1, 1, 1, 32'h0,         2, 1, 0, 1, 32'h0,         32'h0,         7);
    tbl[17] = mk(0, 1, 1, 1, 32'h0,         1, 1, 1, 0, 32'h0,         32'h0,         8);
    tbl[18] = mk(0, 1, 1, 1, 32'h0,         2, 1, 0, 1, 32'h0,         32'h0,         9);
    tbl[19] = mk(0, 1, 1, 1, 32'h0,         1, 1, 1, 0, 32'h0,         32'h0,         10);
    tbl[20] = mk(0, 0, 0, 0, 32'h0,         2, 0, 0, 0, 32'h0,         32'h0,         11);
    tbl[21] = mk(0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0,         32'h0,         11);
    tbl[22] = mk(0, 0, 1, 0, 32'h0,         0, 0, 0, 0, 32'h0,         32'h0,         11);
    tbl[23] = mk(0, 0, 1, 0, 32'h0,         2, 1, 0, 0, 32'h0,         32'h0,         12);
    tbl[24] = mk(0, 0, 0, 0, 32'h0,         2, 0, 0, 0, 32'h0,         32'h0,         12);
    tbl[25] = mk(0, 1, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0,         32'h0,         12);
    tbl[26] = mk(0, 1, 0, 1, 32'h1111_1111, 1, 1, 1, 0, 32'h1111_1111, 32'h0,         13);
    tbl[27] = mk(0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0,         32'h0,         13);
    tbl[28] = mk(0, 1, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0,         32'h0,         13);
    tbl[29] = mk(0, 1, 0, 0, 32'h0,         1, 1, 0, 0, 32'h0,         32'h0,         14);

    #12 rst_ni = 1'b1;
    @(posedge clk); #1;

    ni = 0; nd = 0;
    for (int i = 0; i < NV; i++) begin
      rst_ni        = !tbl[i].rst;
      ib0.valid     = tbl[i].iv;
      db0.valid     = tbl[i].dv;
      mb0.ready     = tbl[i].sr;
      mb0.read_data = tbl[i].srd;
      @(negedge clk);
      chk("grant", i, 32'(g_rr), 32'(tbl[i].g));
      chk("mem_valid", i, 32'(mb0.valid), 32'(tbl[i].mv));
      chk("mem_addr", i, mb0.addr, exp_addr(tbl[i].g));
      chk("mem_wstrb", i, 32'(mb0.wstrb), (tbl[i].g == 2'b10) ? 32'hF : 32'h0);
      chk("mem_wdata", i, mb0.write_data, (tbl[i].g == 2'b10) ? 32'h1234_5678 : 32'h0);
      chk("mem_instr", i, 32'(mb0.instr), (tbl[i].g == 2'b01) ? 32'h1 : 32'h0);
      chk("i_ready", i, 32'(ib0.ready), 32'(tbl[i].ir));
      chk("d_ready", i, 32'(db0.ready), 32'(tbl[i].dr));
      chk("i_rdata", i, ib0.read_data, tbl[i].ird);
      chk("d_rdata", i, db0.read_data, tbl[i].drd);
      chk("contention", i, 32'(c_rr), 32'(tbl[i].cnt));
      if (i >= 12 && i <= 19) begin
        if (ib0.ready && mb0.valid) ni++;
        if (db0.ready && mb0.valid) nd++;
      end
      @(posedge clk); #1;
    end
    chk("burst_i_done", 0, 32'(ni), 32'd4);
    chk("burst_d_done", 0, 32'(nd), 32'd4);

    // Asynchronous reset while the slave stalls an instruction fetch.
    #2;
    chk("rst_pre_grant", 0, 32'(g_rr), 32'h1);
    rst_ni = 1'b0;
    #1;
    chk("rst_grant", 0, 32'(g_rr), 32'h0);
    chk("rst_mem_valid", 0, 32'(mb0.valid), 32'h0);
    chk("rst_i_ready", 0, 32'(ib0.ready), 32'h0);
    chk("rst_d_ready", 0, 32'(db0.ready), 32'h0);
    chk("rst_cnt", 0, 32'(c_rr), 32'h0);
    db0.valid = 1'b1;
    #2 rst_ni = 1'b1;
    @(posedge clk); #1;
    chk("rst_tie_grant", 0, 32'(g_rr), 32'h2);
    chk("rst_tie_addr", 0, mb0.addr, 32'h200);
    ib0.valid = 1'b0; db0.valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Data priority: both masters always requesting, zero-wait slave.
    ib1.valid = 1'b1; db1.valid = 1'b1; mb1.ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("dp_grant", k, 32'(g_dp), (k % 2 == 0) ? 32'h0 : 32'h2);
      chk("dp_i_ready", k, 32'(ib1.ready), 32'h0);
      @(posedge clk); #1;
    end
    db1.valid = 1'b0;
    @(negedge clk);
    chk("dp_idle", 0, 32'(g_dp), 32'h0);
    @(posedge clk); #1;
    db1.valid = 1'b1;
    @(negedge clk);
    chk("dp_grant_i", 0, 32'(g_dp), 32'h1);
    chk("dp_i_done", 0, 32'(ib1.ready), 32'h1);
    chk("dp_d_wait", 0, 32'(db1.ready), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("dp_i_to_d", 0, 32'(g_dp), 32'h2);
    chk("dp_cnt", 0, 32'(c_dp), 32'd8);
    @(posedge clk); #1;
    @(negedge clk);
    chk("dp_d_to_idle", 0, 32'(g_dp), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master, one-slave arbiter for the core's `bus_if` transactions.
- Upstream masters are the instruction-fetch unit and the data load/store unit. Downstream is the single memory/peripheral bus slave.
- Serialises transactions, forwards the granted master's request, and returns `ready`/`read_data` to that master only.
- Grants are registered. The arbiter never splits or reorders a transaction.

Parameters:
- DATA_PRIORITY, default 0: 0 = round-robin between masters; 1 = data master wins whenever both request in IDLE.

Ports:
- clk_i  input  1  core clock
- rst_ni  input  1  asynchronous active-low reset
- instr_bus  bus_if.slave  —  upstream port from instruction fetch
- data_bus  bus_if.slave  —  upstream port from load/store unit
- mem_bus  bus_if.master  —  downstream port to memory/peripheral slave
- grant_o  output  2  current state: 00 IDLE, 01 GRANT_I, 10 GRANT_D
- contention_cnt_o  output  16  cycles in which a requesting master was not granted; saturating

Behaviour:
- Bus protocol, applies on all ports:
  - A master raises `valid` with `addr`/`wstrb`/`write_data`/`instr` stable and holds them until the cycle it samples `ready=1`.
  - `wstrb=0` is a read. Any non-zero `wstrb` is a write with byte enables.
  - A transfer completes in the cycle where `valid && ready`. `read_data` is valid only in that cycle.
- State register reset:
  - Asynchronous reset to IDLE.
  - `grant_o=00`, `contention_cnt_o=0`.
  - Round-robin pointer `last_d=0`, i.e. instruction is treated as last served, so data wins the first tie.
- Output values per state:
  - IDLE:
    - `mem_bus` `valid=0`, `addr=0`, `write_data=0`, `wstrb=0`, `instr=0`.
    - Both upstream ports: `ready=0`, `read_data=0`.
  - GRANT_I / GRANT_D:
    - `mem_bus` request fields are combinationally equal to the granted master's fields, including `valid`.
    - The granted port receives `ready=mem_bus.ready` and `read_data=mem_bus.read_data` combinationally.
    - The non-granted port gets `ready=0`, `read_data=0`.
- IDLE transitions:
  - Only instr valid → GRANT_I.
  - Only data valid → GRANT_D.
  - Both valid:
    - DATA_PRIORITY=1 → GRANT_D.
    - DATA_PRIORITY=0 → master not served last (`last_d`).
  - Neither valid → stay in IDLE.
- Latency: a request first seen in IDLE reaches `mem_bus` one cycle later. No combinational path from upstream `valid` to `mem_bus.valid` exists in IDLE.
- GRANT_x transitions:
  - On completion (`mem_bus.valid && mem_bus.ready`):
    - Set `last_d` to (x==D).
    - If the other master's `valid` is high, move directly to GRANT_other (back-to-back, no bubble).
    - Otherwise move to IDLE.
  - Exception: with DATA_PRIORITY=1, completion in GRANT_D always goes to IDLE.
- Abandoned request: if the granted master drops `valid` before `ready` (protocol violation), return to IDLE next cycle. `last_d` is unchanged.
- Slave `ready` with granted `valid=0` is ignored.
- Wait states: unbounded. The arbiter holds the grant until completion; there is no timeout.
- `contention_cnt_o`:
  - Increments by 1 in every cycle where some master has `valid=1` and that master is not the current grant. This includes both masters in IDLE (counts 1 per cycle, not 2) and a single master waiting in IDLE.
  - Saturates at 16'hFFFF.
- Reset asserted mid-transaction: outputs return to reset values immediately (asynchronous). The downstream transaction is abandoned; slaves must tolerate `valid` dropping on reset.

Decomposition:
- Shared package (`bus_pkg`):
  - typedef enum `arb_state_e {ARB_IDLE, ARB_GRANT_I, ARB_GRANT_D}` with the 2-bit encoding used on `grant_o`.
  - constant `BUS_WSTRB_READ = 4'b0000`.
- No sub-module required. The request/response muxing is a combinational `always_comb` inside `bus_arbiter`.

Test Plan:
- Single instr read to addr 32'h0000_0100; slave ready after 2 wait cycles, data 32'hDEAD_BEEF → `mem_bus.valid` rises 1 cycle after `instr_bus.valid`; `instr_bus.ready` pulses once with read_data DEAD_BEEF; `data_bus.ready` stays 0; `grant_o` goes 01 then 00.
- Both masters request simultaneously from reset, DATA_PRIORITY=0, zero-wait slave:
  - data (write 32'h1234_5678 to 32'h200, `wstrb`=4'b1111) served first.
  - instr then served back-to-back with no IDLE cycle.
  - `contention_cnt_o` = 2 afterwards: 1 in IDLE, 1 while instr waits during GRANT_D.
- Continuous requests on both ports, DATA_PRIORITY=0, 8 transactions → grants strictly alternate D,I,D,I…; each master gets 4 completions.
- DATA_PRIORITY=1, both continuously requesting → data served in every arbitration; instr granted only when data `valid` is low; `grant_o` never shows back-to-back D→I.
- Data master drops `valid` in GRANT_D before `ready` → state IDLE next cycle; `mem_bus.valid` 0; a subsequent instr request is granted normally.
- Assert `rst_ni`=0 during GRANT_I with slave stalling → `grant_o`=00, `mem_bus.valid`=0, both `ready`=0 in the same cycle; `contention_cnt_o`=0; first post-reset tie goes to data.
